// File: rtl/byte_ser_pkg.sv
// Shared types and sizing helpers for the byte serializer.
package byte_ser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 8;

    // Bits needed to count 0..n-1; never less than one.
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Parallel-in, serial-out word transmitter; first bit appears the cycle after the accepting edge.
// Backpressure: ser_en=0 holds the current bit; in_ready only in IDLE or while the last bit is consumed.
module byte_serializer
    import byte_ser_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ser_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int            CW       = clog2_w(DATA_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   shreg_shifted;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                last_bit;

    always_comb begin
        if (MSB_FIRST) begin
            shreg_shifted = {shreg_q[DATA_W-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg_q[DATA_W-1:1]};
        end
    end

    assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    // Gated by rst_n so the source never sees a handshake while reset is held.
    assign in_ready  = rst_n && ((state_q == ST_IDLE) || (last_bit && ser_en));
    assign ser_last  = last_bit;
    assign ser_valid = (state_q == ST_SHIFT);
    assign busy      = (state_q == ST_SHIFT);
    assign ser_out   = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SHIFT;
                    shreg_d = in_data;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (ser_en) begin
                    if (last_bit) begin
                        if (in_valid) begin
                            shreg_d = in_data;
                            cnt_d   = '0;
                        end else begin
                            // Clear residue so ser_out idles low; cnt keeps its value until the next load.
                            state_d = ST_IDLE;
                            shreg_d = '0;
                        end
                    end else begin
                        shreg_d = shreg_shifted;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench: one MSB-first and one LSB-first serializer share the same stimulus.
module tb_byte_serializer;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       ser_en   = 1'b0;

    logic m_rdy, m_vld, m_out, m_last, m_busy;
    logic l_rdy, l_vld, l_out, l_last, l_busy;

    byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_rdy), .in_data(in_data),
        .ser_en(ser_en), .ser_out(m_out), .ser_valid(m_vld), .ser_last(m_last), .busy(m_busy)
    );

    byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_rdy), .in_data(in_data),
        .ser_en(ser_en), .ser_out(l_out), .ser_valid(l_vld), .ser_last(l_last), .busy(l_busy)
    );

    always #5 clk = ~clk;

    // exp = {in_ready, ser_valid, ser_out, ser_last}; busy is expected to equal ser_valid.
    typedef struct {
        bit         sel;
        bit         iv;
        logic [7:0] dat;
        bit         en;
        logic [3:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(input bit s, input bit iv, input logic [7:0] d,
                                input bit en, input logic [3:0] e);
        vq.push_back('{sel: s, iv: iv, dat: d, en: en, exp: e});
    endfunction

    function automatic logic [4:0] obs(input bit sel);
        return sel ? {l_rdy, l_vld, l_out, l_last, l_busy} : {m_rdy, m_vld, m_out, m_last, m_busy};
    endfunction

    task automatic chk(input string name, input int idx, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: rdy/vld/out/last/busy got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        logic       lst;
        logic [3:0] e;

        // 0xA5, MSB first, ser_en held high
        add(0, 1, 8'hA5, 1, 4'b1000);
        add(0, 0, 8'h00, 1, 4'b0110);
        add(0, 0, 8'h00, 1, 4'b0100);
        add(0, 0, 8'h00, 1, 4'b0110);
        add(0, 0, 8'h00, 1, 4'b0100);
        add(0, 0, 8'h00, 1, 4'b0100);
        add(0, 0, 8'h00, 1, 4'b0110);
        add(0, 0, 8'h00, 1, 4'b0100);
        add(0, 0, 8'h00, 1, 4'b1111);
        add(0, 0, 8'h00, 1, 4'b1000);
        // 0xFF then 0x00 back to back; in_data changes while 0xFF is in flight
        add(0, 1, 8'hFF, 1, 4'b1000);
        for (int i = 0; i < 7; i++) add(0, 1, 8'h00, 1, 4'b0110);
        add(0, 1, 8'h00, 1, 4'b1111);
        for (int i = 0; i < 7; i++) add(0, 0, 8'h00, 1, 4'b0100);
        add(0, 0, 8'h00, 1, 4'b1101);
        add(0, 0, 8'h00, 1, 4'b1000);
        // 0xC3 with ser_en low for three cycles on the second bit
        add(0, 1, 8'hC3, 1, 4'b1000);
        add(0, 0, 8'h00, 1, 4'b0110);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 4'b0110);
        add(0, 0, 8'h00, 1, 4'b0110);
        for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 1, 4'b0100);
        add(0, 0, 8'h00, 1, 4'b0110);
        add(0, 0, 8'h00, 1, 4'b1111);
        add(0, 0, 8'h00, 1, 4'b1000);
        // LSB first: 0x01, stall on its last bit, then 0x80 streams in with no gap
        add(1, 1, 8'h01, 0, 4'b1000);
        add(1, 0, 8'h00, 1, 4'b0110);
        for (int i = 0; i < 6; i++) add(1, 0, 8'h00, 1, 4'b0100);
        add(1, 1, 8'h80, 0, 4'b0101);
        add(1, 1, 8'h80, 1, 4'b1101);
        for (int i = 0; i < 7; i++) add(1, 0, 8'h00, 1, 4'b0100);
        add(1, 0, 8'h00, 1, 4'b1111);
        add(1, 0, 8'h00, 1, 4'b1000);

        // Reset state, then release
        #1 rst_n = 1'b0;
        #2;
        chk("reset_msb", 0, obs(0), 5'b00000);
        chk("reset_lsb", 0, obs(1), 5'b00000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release_msb", 0, obs(0), 5'b10000);
        chk("release_lsb", 0, obs(1), 5'b10000);
        @(posedge clk);
        #1;

        foreach (vq[k]) begin
            in_valid = vq[k].iv;
            in_data  = vq[k].dat;
            ser_en   = vq[k].en;
            @(negedge clk);
            e = vq[k].exp;
            chk(vq[k].sel ? "vec_lsb" : "vec_msb", k, obs(vq[k].sel), {e, e[2]});
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-word while bit 4 of 0xF0 is on the line
        in_valid = 1'b1;
        in_data  = 8'hF0;
        ser_en   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_bit4", 0, obs(0), 5'b01101);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_msb", 0, obs(0), 5'b00000);
        chk("async_reset_lsb", 0, obs(1), 5'b00000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        chk("post_reset_idle", 0, obs(0), 5'b10000);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = 8'hFF;
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lst = (i == 7);
            chk("word_3c_msb", i, obs(0), {lst, 1'b1, w[7-i], lst, 1'b1});
            chk("word_3c_lsb", i, obs(1), {lst, 1'b1, w[i], lst, 1'b1});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("final_idle", 0, obs(0), 5'b10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
